multicycle_control: RTL

- Main control unit for the multicycle MIPS core.
- Consumes the opcode/funct fields produced by the instruction decoder, plus the ALU zero flag and a memory ready strobe.
- Sequences the shared ALU, memory port, instruction register, PC and register file through the fetch/decode/execute/memory/writeback steps, and drives every datapath mux and write enable.
- Also counts retired instructions and flags illegal opcodes.

---
 rtl/multicycle_control.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control unit.
// Steps the shared datapath through fetch/decode/execute/memory/writeback,
// drives every mux select and write enable, counts retired instructions and
// flags unsupported opcodes or R-type function codes.
module multicycle_control #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rstb,
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    input  logic         zero,
    input  logic         mem_ready,
    output logic         pc_write,
    output logic         ir_write,
    output logic         mem_write,
    output logic         reg_write,
    output logic         i_or_d,
    output logic         mem_to_reg,
    output logic         reg_dst,
    output logic         alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [1:0]   pc_src,
    output logic [3:0]   alu_control,
    output logic         illegal_op,
    output logic [N-1:0] instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_RWB,
        S_BRANCH,
        S_IEXEC,
        S_IWB,
        S_JUMP
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [N-1:0]   count_reg;
    logic           illegal_reg;
    logic           illegal_next;
    logic           retire;
    logic [3:0]     r_alu;
    logic           r_legal;

    // R-type function code to ALU operation; unknown codes are flagged illegal
    always_comb begin
        r_alu   = 4'b0000;
        r_legal = 1'b1;
        case (funct)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100111: r_alu = ALU_NOR;
            6'b101010: r_alu = ALU_SLT;
            default:   r_legal = 1'b0;
        endcase
    end

    // Next-state selection, retire detection and illegal-op detection
    always_comb begin
        state_next   = state_reg;
        retire       = 1'b0;
        illegal_next = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:              state_next = S_MEMADR;
                    OP_RTYPE:                  state_next = S_EXECUTE;
                    OP_BEQ, OP_BNE:            state_next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_next = S_IEXEC;
                    OP_J:                      state_next = S_JUMP;
                    default: begin
                        state_next   = S_FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (r_legal) begin
                    state_next = S_RWB;
                end else begin
                    state_next   = S_FETCH;
                    illegal_next = 1'b1;
                end
            end
            S_IEXEC: begin
                state_next = S_IWB;
            end
            S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // State, retire counter and registered illegal-op pulse
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_reg   <= S_FETCH;
            count_reg   <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            illegal_reg <= illegal_next;
            if (retire) count_reg <= count_reg + N'(1);
        end
    end

    // Moore control outputs, gated by memory/zero/op where needed and forced low in reset
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        i_or_d      = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_control = 4'b0000;
        case (state_reg)
            S_FETCH: begin
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                ir_write    = mem_ready;
                pc_write    = mem_ready;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
            end
            S_MEMRD: begin
                i_or_d = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                i_or_d    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = r_alu;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                pc_write    = (op == OP_BEQ) ? zero : ~zero;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op)
                    OP_ANDI: alu_control = ALU_AND;
                    OP_ORI:  alu_control = ALU_OR;
                    default: alu_control = ALU_ADD;
                endcase
            end
            S_IWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
        if (!rstb) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            mem_write   = 1'b0;
            reg_write   = 1'b0;
            i_or_d      = 1'b0;
            mem_to_reg  = 1'b0;
            reg_dst     = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            pc_src      = 2'b00;
            alu_control = 4'b0000;
        end
    end

    assign illegal_op  = illegal_reg & rstb;
    assign instr_count = count_reg;

endmodule
